// File: rtl/shift_serial_pkg.sv
// Shared types and default parameters for the serial shift transmitter.
//   state_t   : FSM encoding (IDLE, LOW, HIGH)
//   DEF_WIDTH : default bits per word
//   DEF_HALF  : default clk cycles per strobe half-period
//   DEF_TRAIL : default flush pulses after the data bits
package shift_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_HALF  = 10;
  localparam int unsigned DEF_TRAIL = 3;

endpackage

// File: rtl/shift_phase_timer.sv
// Strobe half-period timer. Counts clk cycles while run is high and flags
// the final cycle of each phase; it restarts from zero after every phase
// end, and it holds at zero while run is low.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   run  : count enable (high whenever the serializer is not idle)
//   last : high in the final cycle of the current phase
module shift_phase_timer #(
  parameter int unsigned HALF = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic last
);

  localparam int unsigned CW = $clog2(HALF + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  logic [CW-1:0] cnt;

  assign last = run && (cnt == HALF_M1);

  always_ff @(posedge clk) begin
    if (rst || !run || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shift_serializer.sv
// Transmitter for a two-wire serial shift interface (data + strobe, data
// sampled by the receiver on the strobe rising edge). A word accepted over
// valid/ready is sent MSB-first as WIDTH strobe pulses, followed by TRAIL
// flush pulses with data held low.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   load_data  : word to transmit
//   load_valid : host offers load_data
//   load_ready : high only while idle
//   shift_out  : shift strobe (registered)
//   d_out      : serial data (registered)
//   busy       : transfer in progress (registered)
//   done       : one-cycle completion pulse (registered)
//
// state | meaning
// IDLE  | waiting for a word; load_ready high
// LOW   | strobe low; d_out holds the current bit (setup time)
// HIGH  | strobe high; d_out unchanged (hold time)
module shift_serializer
  import shift_serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned HALF  = DEF_HALF,
  parameter int unsigned TRAIL = DEF_TRAIL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             shift_out,
  output logic             d_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW = $clog2(WIDTH + TRAIL + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH + TRAIL - 1);

  state_t           state;
  state_t           state_nxt;
  logic             phase_last;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shl;

  assign load_ready = (state == IDLE);
  // Zeros shift in from the bottom, so the trailing flush bits fall out
  // of the register naturally once the data word is exhausted.
  assign shreg_shl  = shreg << 1;

  shift_phase_timer #(
    .HALF (HALF)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (state != IDLE),
    .last (phase_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_valid) state_nxt = LOW;
      LOW:     if (phase_last) state_nxt = HIGH;
      HIGH:    if (phase_last) state_nxt = (bit_cnt < LAST_BIT) ? LOW : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_out <= 1'b0;
      d_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
    end else begin
      state     <= state_nxt;
      shift_out <= (state_nxt == HIGH);
      busy      <= (state_nxt != IDLE);
      done      <= (state == HIGH) && (state_nxt == IDLE);

      if (state == IDLE && state_nxt == LOW) begin
        shreg   <= load_data;
        bit_cnt <= '0;
        d_out   <= load_data[WIDTH-1];
      end else if (state == HIGH && state_nxt == LOW) begin
        shreg   <= shreg_shl;
        bit_cnt <= bit_cnt + BW'(1);
        d_out   <= shreg_shl[WIDTH-1];
      end else if (state == HIGH && state_nxt == IDLE) begin
        d_out   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_serializer.sv
// Directed bench for shift_serializer. Three instances with different
// timing parameters share the clock and reset:
//   0 : HALF=2,  TRAIL=3
//   1 : HALF=10, TRAIL=3
//   2 : HALF=1,  TRAIL=0
module tb_shift_serializer;

  logic        clk;
  logic        rst;
  logic [15:0] ld [3];
  logic [2:0]  lv;
  logic [2:0]  rdy;
  logic [2:0]  so;
  logic [2:0]  dout;
  logic [2:0]  busy;
  logic [2:0]  done;

  int passed;
  int total;

  int          m_rises;
  int          m_first;
  logic [63:0] m_pat;
  int          m_done_n;
  int          m_done1;
  int          m_done2;
  int          m_hold;
  int          m_min;
  int          m_max;
  int          m_busy_low;

  shift_serializer #(.WIDTH(16), .HALF(2), .TRAIL(3)) dut_a (
    .clk(clk), .rst(rst), .load_data(ld[0]), .load_valid(lv[0]),
    .load_ready(rdy[0]), .shift_out(so[0]), .d_out(dout[0]),
    .busy(busy[0]), .done(done[0])
  );

  shift_serializer #(.WIDTH(16), .HALF(10), .TRAIL(3)) dut_b (
    .clk(clk), .rst(rst), .load_data(ld[1]), .load_valid(lv[1]),
    .load_ready(rdy[1]), .shift_out(so[1]), .d_out(dout[1]),
    .busy(busy[1]), .done(done[1])
  );

  shift_serializer #(.WIDTH(16), .HALF(1), .TRAIL(0)) dut_c (
    .clk(clk), .rst(rst), .load_data(ld[2]), .load_valid(lv[2]),
    .load_ready(rdy[2]), .shift_out(so[2]), .d_out(dout[2]),
    .busy(busy[2]), .done(done[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word for a single edge; afterwards the bench sits in cycle k+1.
  task automatic start(input int i, input logic [15:0] data);
    ld[i] = data;
    lv[i] = 1'b1;
    tick();
    lv[i] = 1'b0;
  endtask

  // Observes cycles 1..ncyc of dut i, collecting strobe/data/done events.
  task automatic mon(input int i, input int ncyc, input int drop_at);
    logic pso;
    logic pdo;
    int   last_rise;
    int   d;
    m_rises = 0; m_first = -1; m_pat = '0; m_done_n = 0;
    m_done1 = -1; m_done2 = -1; m_hold = 0; m_min = 1 << 30; m_max = 0;
    m_busy_low = -1; pso = 1'b0; pdo = 1'b0; last_rise = -1;
    for (int c = 1; c <= ncyc; c++) begin
      if (so[i] && !pso) begin
        m_rises++;
        m_pat = {m_pat[62:0], dout[i]};
        if (m_first < 0) m_first = c;
        else begin
          d = c - last_rise;
          if (d < m_min) m_min = d;
          if (d > m_max) m_max = d;
        end
        last_rise = c;
      end
      if (so[i] && pso && (dout[i] !== pdo)) m_hold++;
      if (done[i]) begin
        m_done_n++;
        if (m_done1 < 0) m_done1 = c;
        else if (m_done2 < 0) m_done2 = c;
      end
      if (!busy[i] && m_busy_low < 0) m_busy_low = c;
      pso = so[i];
      pdo = dout[i];
      if (c == drop_at) lv[i] = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lv  = '0;
    for (int i = 0; i < 3; i++) ld[i] = 16'h0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({rdy[i], busy[i], so[i], dout[i], done[i]} !== 5'b10000)
        $display("FAIL reset_state dut%0d: got rdy/busy/so/d/done=%b expected 10000",
                 i, {rdy[i], busy[i], so[i], dout[i], done[i]});
      else passed++;
    end
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      if ({rdy[0], busy[0], so[0], dout[0], done[0]} !== 5'b10000) bad++;
      tick();
    end
    total++;
    if (bad !== 0) $display("FAIL idle_quiet: got %0d bad cycles expected 0", bad);
    else passed++;
  endtask

  task automatic test_ffff();
    start(0, 16'hFFFF);
    total++;
    if ({busy[0], rdy[0]} !== 2'b10)
      $display("FAIL ffff_accept: got busy/rdy=%b expected 10", {busy[0], rdy[0]});
    else passed++;
    mon(0, 90, 0);
    total++;
    if (m_rises !== 19) $display("FAIL ffff_rises: got %0d expected 19", m_rises);
    else passed++;
    total++;
    if (m_first !== 3) $display("FAIL ffff_first_rise: got %0d expected 3", m_first);
    else passed++;
    total++;
    if (m_pat[18:0] !== 19'b1111111111111111000)
      $display("FAIL ffff_pattern: got %b expected 1111111111111111000", m_pat[18:0]);
    else passed++;
    total++;
    if (m_done_n !== 1 || m_done1 !== 77)
      $display("FAIL ffff_done: got count %0d at cycle %0d expected 1 at 77", m_done_n, m_done1);
    else passed++;
    total++;
    if (m_busy_low !== 77)
      $display("FAIL ffff_busy_end: got first idle cycle %0d expected 77", m_busy_low);
    else passed++;
    total++;
    if (m_min !== 4 || m_max !== 4)
      $display("FAIL ffff_period: got %0d..%0d expected 4..4", m_min, m_max);
    else passed++;
  endtask

  task automatic test_a5c3();
    start(0, 16'hA5C3);
    mon(0, 90, 0);
    total++;
    if (m_pat[18:0] !== 19'b1010010111000011000)
      $display("FAIL a5c3_pattern: got %b expected 1010010111000011000", m_pat[18:0]);
    else passed++;
    total++;
    if (m_hold !== 0) $display("FAIL a5c3_hold: got %0d changes while high expected 0", m_hold);
    else passed++;
    total++;
    if (m_rises !== 19) $display("FAIL a5c3_rises: got %0d expected 19", m_rises);
    else passed++;
  endtask

  task automatic test_reset_mid();
    start(1, 16'h5A5A);
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({so[1], dout[1], busy[1], rdy[1]} !== 4'b0001)
      $display("FAIL midrst_state: got so/d/busy/rdy=%b expected 0001",
               {so[1], dout[1], busy[1], rdy[1]});
    else passed++;
    mon(1, 400, 0);
    total++;
    if (m_done_n !== 0 || m_rises !== 0)
      $display("FAIL midrst_quiet: got done %0d rises %0d expected 0 0", m_done_n, m_rises);
    else passed++;
    start(1, 16'h3C96);
    mon(1, 390, 0);
    total++;
    if (m_done_n !== 1 || m_done1 !== 381)
      $display("FAIL midrst_restart_done: got count %0d at %0d expected 1 at 381", m_done_n, m_done1);
    else passed++;
    total++;
    if (m_pat[18:0] !== 19'b0011110010010110000)
      $display("FAIL midrst_restart_pattern: got %b expected 0011110010010110000", m_pat[18:0]);
    else passed++;
    total++;
    if (m_first !== 11) $display("FAIL midrst_first_rise: got %0d expected 11", m_first);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [37:0] exp_pat;
    exp_pat = {16'hC3A5, 3'b000, 16'h0FF0, 3'b000};
    ld[0] = 16'hC3A5;
    lv[0] = 1'b1;
    tick();
    ld[0] = 16'h0FF0;
    mon(0, 170, 78);
    total++;
    if (m_done_n !== 2 || m_done1 !== 77 || m_done2 !== 154)
      $display("FAIL b2b_done: got count %0d at %0d,%0d expected 2 at 77,154",
               m_done_n, m_done1, m_done2);
    else passed++;
    total++;
    if (m_pat[37:0] !== exp_pat)
      $display("FAIL b2b_pattern: got %b expected %b", m_pat[37:0], exp_pat);
    else passed++;
    total++;
    if (m_rises !== 38) $display("FAIL b2b_rises: got %0d expected 38", m_rises);
    else passed++;
    total++;
    if (m_busy_low !== 77) $display("FAIL b2b_busy_gap: got %0d expected 77", m_busy_low);
    else passed++;
  endtask

  task automatic test_half1();
    start(2, 16'h8001);
    mon(2, 40, 0);
    total++;
    if (m_rises !== 16) $display("FAIL half1_rises: got %0d expected 16", m_rises);
    else passed++;
    total++;
    if (m_pat[15:0] !== 16'h8001) $display("FAIL half1_pattern: got %h expected 8001", m_pat[15:0]);
    else passed++;
    total++;
    if (m_min !== 2 || m_max !== 2)
      $display("FAIL half1_period: got %0d..%0d expected 2..2", m_min, m_max);
    else passed++;
    total++;
    if (m_done_n !== 1 || m_done1 !== 33)
      $display("FAIL half1_done: got count %0d at %0d expected 1 at 33", m_done_n, m_done1);
    else passed++;
    total++;
    if (m_first !== 2) $display("FAIL half1_first_rise: got %0d expected 2", m_first);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    lv     = '0;
    test_reset();
    test_idle();
    test_ffff();
    test_a5c3();
    test_reset_mid();
    test_back_to_back();
    test_half1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/shift_serializer.md
Name: shift_serializer

Overview:
- Transmitter end of the two-wire serial shift interface: a data line plus a shift strobe, with data sampled on the strobe's rising edge.
- Accepts a parallel word over a valid/ready handshake.
- Drives the word MSB-first as WIDTH strobe pulses, then TRAIL flush pulses with data held at 0.
- Sits between a host register/FSM and any serial shift-register receiver in the design, e.g. on the board header pins.

Parameters:
- WIDTH, 16, bits per word.
- HALF, 10, clk cycles per strobe half-period (low phase = high phase = HALF); legal range 1..255.
- TRAIL, 3, flush pulses after the data bits, with d_out=0; legal range 0..15.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- load_data  input  WIDTH  word to transmit.
- load_valid  input  1  host offers load_data.
- load_ready  output  1  block can accept a word (high only in IDLE).
- shift_out  output  1  shift strobe to the receiver.
- d_out  output  1  serial data to the receiver.
- busy  output  1  high from acceptance until the last flush period ends.
- done  output  1  one-cycle pulse when the transfer completes.

Behaviour:
- Reset (rst high at a clk edge) overrides everything, including mid-transfer.
  - Next cycle: state=IDLE, shift_out=0, d_out=0, busy=0, done=0, load_ready=1.
  - Any transfer in progress is abandoned; the shift register contents are don't-care.
- All outputs except load_ready are registered. load_ready is a decode of state==IDLE.
- Acceptance:
  - Occurs when load_valid and load_ready are both high at edge k.
  - load_data is captured into the shift register; state goes to LOW.
  - busy=1 from cycle k+1.
  - load_valid while not IDLE is ignored: no capture and no error.
- States: IDLE, LOW, HIGH.
- Period n (n=0 .. WIDTH+TRAIL-1) occupies cycles k+1+2·HALF·n .. k+2·HALF·(n+1).
  - LOW phase, first HALF cycles:
    - shift_out=0.
    - d_out = bit WIDTH-1-n for n<WIDTH, else 0.
  - HIGH phase, next HALF cycles:
    - shift_out=1.
    - d_out unchanged.
  - d_out changes only on the HIGH→LOW transition. This gives HALF cycles of setup before the rising edge and HALF cycles of hold after it.
  - Transitions:
    - LOW→HIGH when the phase counter reaches HALF-1.
    - HIGH→LOW (next period) when the phase counter reaches HALF-1 and the bit counter is below WIDTH+TRAIL-1.
    - Otherwise HIGH→IDLE.
- Completion, in cycle k+2·HALF·(WIDTH+TRAIL)+1:
  - done=1, busy=0, shift_out=0, d_out=0, load_ready=1.
  - done lasts exactly one cycle.
- Back-to-back: a word accepted in the done cycle starts its LOW phase in the next cycle. Throughput is one word per 2·HALF·(WIDTH+TRAIL)+1 cycles.
- Counters:
  - Phase counter: clog2(HALF+1) bits, wraps to 0 at each phase change.
  - Bit counter: clog2(WIDTH+TRAIL+1) bits, cleared on acceptance.
  - No counter overflows within the legal parameter ranges.
- HALF=1: the strobe toggles every cycle; the same equations hold.
- TRAIL=0: the block goes straight to IDLE after bit 0.

Decomposition:
- Package shift_serial_pkg holds:
  - the state enum (IDLE, LOW, HIGH);
  - default constants DEF_WIDTH=16, DEF_HALF=10, DEF_TRAIL=3.
- One sub-module: shift_phase_timer.
  - Parameterised by HALF.
  - Inputs: clk, rst, run.
  - Output: last, which flags phase end.
  - It restarts at each phase boundary.
- The top level holds the FSM, the shift register and the bit counter.

Test Plan:
- HALF=2, load_data=16'hFFFF accepted at cycle 0:
  - 19 rising edges on shift_out; the first shift_out=1 is at cycle 3;
  - d_out at those edges is sixteen 1s then three 0s;
  - done=1 at cycle 77 only.
- HALF=2, load_data=16'hA5C3:
  - d_out sampled at the rising edges reads 1010010111000011 then 000;
  - d_out never changes while shift_out=1.
- rst asserted at cycle 20 of a HALF=10 transfer:
  - next cycle shift_out=0, d_out=0, busy=0, load_ready=1;
  - no done pulse follows;
  - a new word is accepted normally afterwards.
- load_valid held high continuously with two words:
  - the second word is accepted exactly in the first word's done cycle;
  - no extra word is captured while busy.
- HALF=1, TRAIL=0, load_data=16'h8001:
  - 16 strobe pulses with period 2;
  - d_out pattern 1, fourteen 0s, then 1;
  - done at cycle 33.
- load_valid=0 for 100 cycles after reset: shift_out=0, d_out=0, busy=0, load_ready=1 throughout.
